bg_tile_fetcher: RTL

Background tile fetch sequencer for the PPU render path. It sits directly downstream of the pixel-to-nametable address stage and takes the nametable pointer and fine-Y row offset produced there. It runs the four PPU memory reads for one 8-pixel background tile: nametable byte, attribute byte, pattern low plane and pattern high plane. It then presents the two pattern bytes and the 2-bit palette select to the background shifters with a one-cycle valid strobe.

---
 rtl/bg_tile_fetcher.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bg_tile_fetcher.sv
// Background tile fetch sequencer: four PPU reads (nametable, attribute, pattern
// low/high) per 8-pixel tile, presented to the shifters with a one-cycle strobe.
module bg_tile_fetcher (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] nametable_ptr,
    input  logic [2:0]  pattern_table_offset,
    input  logic [7:0]  ppu_ctrl1,
    output logic [15:0] mem_addr,
    output logic        mem_rd_req,
    input  logic [7:0]  mem_rd_data,
    input  logic        mem_rd_valid,
    output logic [7:0]  tile_pattern_lo,
    output logic [7:0]  tile_pattern_hi,
    output logic [1:0]  tile_palette,
    output logic        tile_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        F_NT,
        F_AT,
        F_PL,
        F_PH,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] p_q;
    logic [2:0]  y_q;
    logic        s_q;
    logic [7:0]  t_q;
    logic [7:0]  a_q;
    logic [7:0]  lo_q;
    logic [7:0]  pat_lo_q, pat_hi_q;
    logic [1:0]  pal_q;
    logic [15:0] at_addr;
    logic [1:0]  palette;
    logic        fire;
    logic        unused_ctrl;

    assign unused_ctrl = ^{ppu_ctrl1[7:5], ppu_ctrl1[3:0]};

    // Attribute byte covers a 4x4-tile block; select the 2x2 quadrant's two bits.
    assign at_addr = 16'h23C0 | (p_q & 16'h0C00) | ((p_q >> 4) & 16'h0038) | ((p_q >> 2) & 16'h0007);

    always_comb begin
        palette = a_q[1:0];
        case ({p_q[6], p_q[1]})
            2'b00:   palette = a_q[1:0];
            2'b01:   palette = a_q[3:2];
            2'b10:   palette = a_q[5:4];
            default: palette = a_q[7:6];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mem_rd_req = 1'b0;
        mem_addr   = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = F_NT;
            end
            F_NT: begin
                mem_rd_req = 1'b1;
                mem_addr   = p_q;
                if (mem_rd_valid) state_d = F_AT;
            end
            F_AT: begin
                mem_rd_req = 1'b1;
                mem_addr   = at_addr;
                if (mem_rd_valid) state_d = F_PL;
            end
            F_PL: begin
                mem_rd_req = 1'b1;
                mem_addr   = {3'b000, s_q, t_q, 1'b0, y_q};
                if (mem_rd_valid) state_d = F_PH;
            end
            F_PH: begin
                mem_rd_req = 1'b1;
                mem_addr   = {3'b000, s_q, t_q, 1'b1, y_q};
                if (mem_rd_valid) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fire = mem_rd_req & mem_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q      <= '0;
            y_q      <= '0;
            s_q      <= 1'b0;
            t_q      <= '0;
            a_q      <= '0;
            lo_q     <= '0;
            pat_lo_q <= '0;
            pat_hi_q <= '0;
            pal_q    <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                p_q <= nametable_ptr;
                y_q <= pattern_table_offset;
                s_q <= ppu_ctrl1[4];
            end
            if (fire) begin
                case (state_q)
                    F_NT: t_q  <= mem_rd_data;
                    F_AT: a_q  <= mem_rd_data;
                    F_PL: lo_q <= mem_rd_data;
                    // Outputs load together on entry to DONE so all three change in the strobe cycle.
                    F_PH: begin
                        pat_lo_q <= lo_q;
                        pat_hi_q <= mem_rd_data;
                        pal_q    <= palette;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tile_pattern_lo = pat_lo_q;
    assign tile_pattern_hi = pat_hi_q;
    assign tile_palette    = pal_q;
    assign tile_valid      = (state_q == DONE);
    assign busy            = (state_q != IDLE);

endmodule
